// File: rtl/codes.sv
// -----------------------------------------------------------------------------
// codes: shared types for the CPU memory path.
//   size_t           - 32-bit byte address / data word
//   mem_size_t       - access width of a CPU load/store (BYTE, HALF, WORD)
//   mem_init_state_t - state encoding of the mem_initiator bus FSM
// -----------------------------------------------------------------------------
package codes;

    typedef logic [31:0] size_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        RESP    = 3'd4,
        ERR     = 3'd5
    } mem_init_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align: combinational byte-lane steering for a 32-bit little-endian
// bus.
//   size_i        access size (mem_size_t encoding; 3 is illegal)
//   addr_lo_i     byte offset within the word
//   signed_i      sign-extend load data when set
//   wdata_i       right-justified store data
//   rdata_i       raw bus read word
//   byteenable_o  active byte lanes
//   wdata_o       store data replicated into every lane it may occupy
//   rdata_o       selected lane shifted to bit 0, sign/zero extended
//   misaligned_o  offset violates the natural alignment, or size is illegal
// -----------------------------------------------------------------------------
module mem_lane_align
    import codes::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byteenable_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [31:0] rdata_shift;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        rdata_shift = rdata_i >> {addr_lo_i, 3'b000};
        lane_byte   = rdata_shift[7:0];
        lane_half   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // Illegal size falls through to the defaults and is flagged.
        byteenable_o = 4'b0000;
        wdata_o      = wdata_i;
        rdata_o      = 32'd0;
        misaligned_o = 1'b1;

        case (size_i)
            BYTE: begin
                byteenable_o = 4'b0001 << addr_lo_i;
                wdata_o      = {4{wdata_i[7:0]}};
                rdata_o      = {{24{signed_i & lane_byte[7]}}, lane_byte};
                misaligned_o = 1'b0;
            end
            HALF: begin
                byteenable_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = {{16{signed_i & lane_half[15]}}, lane_half};
                misaligned_o = addr_lo_i[0];
            end
            WORD: begin
                byteenable_o = 4'b1111;
                wdata_o      = wdata_i;
                rdata_o      = rdata_i;
                misaligned_o = |addr_lo_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_initiator.sv
// -----------------------------------------------------------------------------
// mem_initiator: turns one CPU load/store into a single word-aligned Avalon-MM
// transfer and returns extended load data or a store completion.
//   clk, reset            rising-edge clock, async active-high reset
//   req_valid/req_ready   CPU request handshake (ready only while idle)
//   req_write, req_size, req_signed, req_addr, req_wdata   request fields
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  load result / misalignment flag (0 when not valid)
//   read, write, address, byteenable, writedata   Avalon command side
//   readdata, waitrequest                          Avalon response side
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_initiator
    import codes::*;
#(
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    // Plain 2-bit vector so the illegal encoding 3 can be presented and caught.
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  size_t       req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        read,
    output logic        write,
    output logic [31:0] address,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    mem_init_state_t state_q;
    logic [1:0]      size_q;
    logic [1:0]      addr_lo_q;
    logic            signed_q;

    logic            is_idle;
    logic [1:0]      al_size;
    logic [1:0]      al_addr_lo;
    logic            al_signed;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata;
    logic [31:0]     al_rdata;
    logic            al_misaligned;

    // One aligner serves both phases: while idle it looks at the incoming
    // request (byteenable, writedata, alignment); afterwards it sees the
    // captured request so the load extraction uses the accepted size/offset.
    assign is_idle    = (state_q == IDLE);
    assign al_size    = is_idle ? req_size        : size_q;
    assign al_addr_lo = is_idle ? req_addr[1:0]   : addr_lo_q;
    assign al_signed  = is_idle ? req_signed      : signed_q;

    mem_lane_align u_align (
        .size_i       (al_size),
        .addr_lo_i    (al_addr_lo),
        .signed_i     (al_signed),
        .wdata_i      (req_wdata),
        .rdata_i      (readdata),
        .byteenable_o (al_be),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            size_q     <= 2'd0;
            addr_lo_q  <= 2'd0;
            signed_q   <= 1'b0;
            req_ready  <= 1'b1;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= 32'd0;
            byteenable <= 4'd0;
            writedata  <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        size_q    <= req_size;
                        addr_lo_q <= req_addr[1:0];
                        signed_q  <= req_signed;
                        req_ready <= 1'b0;
                        if (al_misaligned) begin
                            // No bus traffic; report the error next cycle.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                            state_q    <= ERR;
                        end else begin
                            // Bus fields are loaded once here and held for
                            // the whole strobe, however long waitrequest lasts.
                            address    <= req_addr & ADDR_MASK;
                            byteenable <= al_be;
                            if (req_write) begin
                                writedata <= al_wdata;
                                write     <= 1'b1;
                                state_q   <= WR_REQ;
                            end else begin
                                read    <= 1'b1;
                                state_q <= RD_REQ;
                            end
                        end
                    end
                end
                RD_REQ: begin
                    if (!waitrequest) begin
                        read    <= 1'b0;
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    // Responder returns data one cycle after accepting.
                    resp_rdata <= al_rdata;
                    resp_valid <= 1'b1;
                    state_q    <= RESP;
                end
                WR_REQ: begin
                    if (!waitrequest) begin
                        write      <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'd0;
                        state_q    <= RESP;
                    end
                end
                RESP, ERR: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    read       <= 1'b0;
                    write      <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Avalon-MM initiator that sits between the CPU datapath and the memory bus. It turns one CPU load or store request (byte, halfword or word; signed or unsigned) into a single word-aligned bus transfer with the correct byteenable. It honours `waitrequest`, then returns lane-extracted, sign- or zero-extended load data or a store completion. It is the initiator-side counterpart of the bus RAM and other Avalon responders in the design.

## Interface
- Reset: one clock (`clk`); reset is asynchronous and active-high (`reset`).
- Parameters:
  - `ADDR_MASK`, default `32'hFFFF_FFFC`: mask applied to the request address to form `address`.
- Ports, clock and reset first:
  - `clk`  in  1: rising-edge clock.
  - `reset`  in  1: asynchronous, active-high.
  - `req_valid`  in  1: the CPU presents a request.
  - `req_ready`  out  1: the block can accept a request; high only in IDLE.
  - `req_write`  in  1: 1 = store, 0 = load.
  - `req_size`  in  2: `mem_size_t` (BYTE=0, HALF=1, WORD=2; 3 is illegal).
  - `req_signed`  in  1: sign-extend the load result.
  - `req_addr`  in  32 (`size_t`): byte address.
  - `req_wdata`  in  32: store data, right-justified.
  - `resp_valid`  out  1: one-cycle pulse when a request completes.
  - `resp_rdata`  out  32: extended load data; 0 for stores and errors.
  - `resp_err`  out  1: the request was misaligned or illegal; no bus transfer was made.
  - `read`, `write`  out  1 each: Avalon strobes.
  - `address`  out  32: word-aligned Avalon address.
  - `byteenable`  out  4: Avalon byte lanes.
  - `writedata`  out  32: Avalon store data.
  - `readdata`  in  32: Avalon read data.
  - `waitrequest`  in  1: the responder stalls the transfer.

## Operation
- Acceptance: a request is accepted on a rising edge where `req_valid && req_ready`. All request fields are registered at that edge; inputs are ignored at all other times.
- Alignment:
  - HALF requires `addr[0]==0`. WORD requires `addr[1:0]==0`.
  - A violation, or `req_size==3`, sends the FSM to ERR: no strobe is asserted, then `resp_valid=1` and `resp_err=1`.
- Byteenable:
  - BYTE: `4'b0001 << addr[1:0]`.
  - HALF: `addr[1] ? 4'b1100 : 4'b0011`.
  - WORD: `4'b1111`.
- Writedata:
  - BYTE: the low byte replicated into all four lanes.
  - HALF: the low half replicated into both halves.
  - WORD: passed through unchanged.
- Load extraction: the selected lane is shifted to bit 0, then sign-extended if `req_signed`, else zero-extended. Little-endian: lane 0 is `readdata[7:0]`.
- FSM states and transitions:
  - IDLE: on accept, go to ERR if misaligned, else RD_REQ or WR_REQ.
  - RD_REQ: `read=1`. Stay while `waitrequest`; on `!waitrequest` go to RD_DATA.
  - RD_DATA: strobes low. Capture `readdata` at the end of this cycle, then go to RESP.
  - WR_REQ: `write=1`. Stay while `waitrequest`; on `!waitrequest` go to RESP.
  - ERR and RESP: `resp_valid=1` for exactly one cycle, then go to IDLE.
- Strobe stability: `address`, `byteenable` and `writedata` are held stable for the whole time a strobe is asserted. `read` and `write` are never high together.

## Timing
- Reset values: state=IDLE, `req_ready=1`, `read=0`, `write=0`, `address=0`, `byteenable=0`, `writedata=0`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`.
- Read latency from the responder: `readdata` is valid in the cycle after the transfer is accepted (`read && !waitrequest`).
- Load, accepted at edge t with no wait states:
  - `read` high during cycle t+1.
  - Data captured at the end of t+2.
  - `resp_valid` high in t+3.
  - Each wait cycle adds 1.
- Store, accepted at edge t: `write` high from t+1 until accepted; `resp_valid` is high in the cycle after acceptance.
- Error, accepted at edge t: `resp_valid` and `resp_err` are high in t+1.
- Back-to-back: `req_ready` returns high in the cycle after the RESP/ERR cycle. There is no pipelining, so only one request is outstanding.
- `resp_*` outputs are registered. `resp_rdata` and `resp_err` are 0 whenever `resp_valid` is 0.
- Reset mid-transfer: all strobes drop immediately (asynchronous), any pending response is discarded, and the FSM goes to IDLE. The responder must tolerate the abandoned transfer.

## Structure
- Package `codes` gains:
  - `typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_t;`
  - the FSM state enum `mem_init_state_t`.
- `size_t` is reused from `codes`.
- One combinational sub-module, `mem_lane_align`, takes (size, addr[1:0], signed, wdata, readdata) and returns (byteenable, aligned writedata, extended rdata, misaligned). It is shared with the verification model.

## Test plan
- LB signed: addr `0xBFC00003`, readdata `0x80FF_0000`, `waitrequest=0`. Expect `address=0xBFC00000`, `byteenable=1000`, `resp_rdata=0xFFFF_FF80`, `resp_valid` at t+3.
- LHU: addr `0xBFC00006`, readdata `0xBEEF_1234`. Expect `byteenable=1100`, `resp_rdata=0x0000_BEEF`.
- SB with 3 wait cycles: addr `0xBFC00001`, wdata `0x0000_00AB`. Expect `writedata=0xABABABAB`, `byteenable=0010`, and `write` plus all bus fields stable for 4 cycles; `resp_valid` in the cycle after acceptance.
- Misaligned LW at `0xBFC00002`. Expect `read` and `write` never asserted; `resp_valid=1`, `resp_err=1` at t+1; `req_ready` high at t+2.
- `reset` asserted mid-RD_REQ with `waitrequest=1`. Expect `read=0` immediately, no `resp_valid`, and `req_ready=1` after `reset` deasserts.
- Back-to-back SW then LW at the same address against the bus RAM. Expect the load to return the stored word, and never `read` and `write` high together.
